isp_demosaic: RTL and testbench

Bilinear Bayer-to-RGB demosaic stage that sits directly downstream of `isp_bnr` in the ISP chain and consumes its `out_href`/`out_vsync`/`out_raw` stream. It builds a 3x3 raw window from two internal line buffers, interpolates the two missing colour channels at every site according to the configured Bayer phase, and emits full-resolution R/G/B planes. The strobes are delayed by a fixed pipeline latency, so the HDMI packing stage can use them unchanged.

---
 rtl/isp_pkg.sv | 35 +++
 rtl/isp_demosaic_linebuf.sv | 28 ++
 rtl/isp_demosaic.sv | 203 ++++++++++++++++++++
 tb/tb_isp_demosaic.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Purpose: shared ISP definitions (Bayer phase codes, CFA site types, site lookup).
// Latency: n/a (package only).
// Backpressure: n/a.
package isp_pkg;

    // Colour of the pixel at (even row, even col).
    localparam int BAYER_RGGB = 0;
    localparam int BAYER_GRBG = 1;
    localparam int BAYER_GBRG = 2;
    localparam int BAYER_BGGR = 3;

    // CFA site classes. GR is a green site on a red row, GB is a green site on a blue row.
    typedef enum logic [1:0] {
        SITE_R  = 2'd0,
        SITE_GR = 2'd1,
        SITE_GB = 2'd2,
        SITE_B  = 2'd3
    } site_t;

    // Every phase is RGGB shifted by one row and/or one column.
    // GRBG flips the column parity, GBRG flips the row parity, and BGGR flips both.
    function automatic site_t site_of(input int bayer, input logic row_odd, input logic col_odd);
        logic r;
        logic c;
        r = row_odd ^ bayer[1];
        c = col_odd ^ bayer[0];
        case ({r, c})
            2'b00:   return SITE_R;
            2'b01:   return SITE_GR;
            2'b10:   return SITE_GB;
            default: return SITE_B;
        endcase
    endfunction

endpackage

// File: rtl/isp_demosaic_linebuf.sv
// Purpose: simple dual-port line RAM, DEPTH x DW. The read is combinational and returns the old word on a same-address write.
// Latency: read 0 cycles, write lands on the next pclk edge.
// Backpressure: none; one write per cycle while we=1.
// Ports: pclk clock; we/waddr/wdata write port; raddr/rdata read port.
module isp_demosaic_linebuf #(
    parameter int DW    = 16,
    parameter int DEPTH = 1920,
    parameter int AW    = 11
) (
    input  logic          pclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/isp_demosaic.sv
// Purpose: bilinear Bayer-to-RGB demosaic. It builds a 3x3 window from two line buffers and mirror-clamps the frame edges.
// Latency: 4 pclk from in_* to out_*. This holds for the strobes and for the pixel data.
// Backpressure: none; this is a streaming pixel pipe that follows in_href.
// Ports: pclk, rst_n (async, active low); in_href/in_vsync/in_raw raw input stream;
//        out_href/out_vsync are the delayed strobes; out_r/out_g/out_b are 0 outside out_href.
module isp_demosaic
    import isp_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1920,
    parameter int HEIGHT = 1080,
    parameter int BAYER  = BAYER_RGGB
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_raw,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_r,
    output logic [BITS-1:0] out_g,
    output logic [BITS-1:0] out_b
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int SW2 = BITS + 1;
    localparam int SW4 = BITS + 2;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [CW-1:0] col_cnt, col_d1, col_d2;
    logic [RW-1:0] row_cnt, row_d1, row_d2;
    logic [3:0]    href_d, vsync_d;

    // Counters. href_d[0] and vsync_d[0] hold the previous input, which is used for edge detection.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            if (!in_href)
                col_cnt <= '0;
            else if (col_cnt != COL_LAST)
                col_cnt <= col_cnt + 1'b1;

            if (in_vsync && !vsync_d[0])
                row_cnt <= '0;
            else if (!in_href && href_d[0] && row_cnt != ROW_LAST)
                row_cnt <= row_cnt + 1'b1;
        end
    end

    // Strobe delay line, plus the column and row of the window centre.
    // The centre is the sample taken two cycles ago.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_d  <= '0;
            vsync_d <= '0;
            col_d1  <= '0;
            col_d2  <= '0;
            row_d1  <= '0;
            row_d2  <= '0;
        end else begin
            href_d  <= {href_d[2:0], in_href};
            vsync_d <= {vsync_d[2:0], in_vsync};
            col_d1  <= col_cnt;
            col_d2  <= col_d1;
            row_d1  <= row_cnt;
            row_d2  <= row_d1;
        end
    end

    assign out_href  = href_d[3];
    assign out_vsync = vsync_d[3];

    // One RAM word holds {row y-1, row y-2}. Writing {in_raw, row y-1} rolls both lines in a single access.
    logic [2*BITS-1:0] lb_rd;
    logic [BITS-1:0]   col_top;

    isp_demosaic_linebuf #(
        .DW    (2 * BITS),
        .DEPTH (WIDTH),
        .AW    (CW)
    ) u_linebuf (
        .pclk  (pclk),
        .we    (in_href),
        .waddr (col_cnt),
        .wdata ({in_raw, lb_rd[2*BITS-1:BITS]}),
        .raddr (col_cnt),
        .rdata (lb_rd)
    );

    // When input row 1 arrives, the centre is row 0. Its missing upper neighbour is mirrored to row 1.
    assign col_top = (row_cnt == ROW_ONE) ? in_raw : lb_rd[BITS-1:0];

    // 3x3 window. Index 2 is the newest (rightmost) column.
    logic [BITS-1:0] win_t [3];
    logic [BITS-1:0] win_m [3];
    logic [BITS-1:0] win_b [3];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                win_t[i] <= '0;
                win_m[i] <= '0;
                win_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                win_t[i] <= win_t[i+1];
                win_m[i] <= win_m[i+1];
                win_b[i] <= win_b[i+1];
            end
            win_t[2] <= col_top;
            win_m[2] <= lb_rd[2*BITS-1:BITS];
            win_b[2] <= in_raw;
        end
    end

    // Horizontal mirror clamp. The Bayer period is 2, so the column two steps in has the same colour.
    // At the right edge, the newest column is blanking data and is always replaced.
    logic            edge_l, edge_r;
    logic [BITS-1:0] l_t, l_m, l_b, r_t, r_m, r_b;
    logic [SW4-1:0]  sum_cross, sum_diag;
    logic [SW2-1:0]  sum_ew, sum_ns;

    assign edge_l = (col_d2 == '0);
    assign edge_r = (col_d2 == COL_LAST);
    assign l_t = edge_l ? win_t[2] : win_t[0];
    assign l_m = edge_l ? win_m[2] : win_m[0];
    assign l_b = edge_l ? win_b[2] : win_b[0];
    assign r_t = edge_r ? win_t[0] : win_t[2];
    assign r_m = edge_r ? win_m[0] : win_m[2];
    assign r_b = edge_r ? win_b[0] : win_b[2];

    assign sum_cross = SW4'(win_t[1]) + SW4'(win_b[1]) + SW4'(l_m) + SW4'(r_m);
    assign sum_diag  = SW4'(l_t) + SW4'(r_t) + SW4'(l_b) + SW4'(r_b);
    assign sum_ew    = SW2'(l_m) + SW2'(r_m);
    assign sum_ns    = SW2'(win_t[1]) + SW2'(win_b[1]);

    // Sum stage. It registers the truncated averages, the centre value, the site class and the blanking/black flags.
    logic [BITS-1:0] s_cross, s_diag, s_ew, s_ns, s_c;
    site_t           s_site;
    logic            s_href, s_black;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s_cross <= '0;
            s_diag  <= '0;
            s_ew    <= '0;
            s_ns    <= '0;
            s_c     <= '0;
            s_site  <= SITE_R;
            s_href  <= 1'b0;
            s_black <= 1'b0;
        end else begin
            s_cross <= sum_cross[SW4-1:2];
            s_diag  <= sum_diag[SW4-1:2];
            s_ew    <= sum_ew[SW2-1:1];
            s_ns    <= sum_ns[SW2-1:1];
            s_c     <= win_m[1];
            // row_d2 is the input row and the centre is one row above it, so the centre row parity is inverted.
            s_site  <= site_of(BAYER, ~row_d2[0], col_d2[0]);
            s_href  <= href_d[1];
            s_black <= (row_d2 == '0);
        end
    end

    // Channel select and output register.
    logic [BITS-1:0] r_sel, g_sel, b_sel;

    always_comb begin
        r_sel = s_c;
        g_sel = s_c;
        b_sel = s_c;
        case (s_site)
            SITE_R:  begin g_sel = s_cross; b_sel = s_diag; end
            SITE_B:  begin g_sel = s_cross; r_sel = s_diag; end
            SITE_GR: begin r_sel = s_ew;    b_sel = s_ns;   end
            default: begin r_sel = s_ns;    b_sel = s_ew;   end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
            out_g <= '0;
            out_b <= '0;
        end else if (s_href && !s_black) begin
            out_r <= r_sel;
            out_g <= g_sel;
            out_b <= b_sel;
        end else begin
            out_r <= '0;
            out_g <= '0;
            out_b <= '0;
        end
    end

endmodule

// File: tb/tb_isp_demosaic.sv
// Purpose: scoreboard bench for isp_demosaic. It drives the RGGB and BGGR instances in parallel on an 8x6 frame.
// Latency: the expected strobes are the inputs shifted by 4 pclk cycles.
// Backpressure: none.
`timescale 1ns/1ps
module tb_isp_demosaic;

    localparam int W = 8;
    localparam int H = 6;
    localparam int B = 8;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_href = 1'b0;
    logic       in_vsync = 1'b0;
    logic [7:0] in_raw = 8'd0;
    logic       in_chk = 1'b0;

    logic       h0, v0, h3, v3;
    logic [7:0] r0, g0, b0, r3, g3, b3;

    always #5 pclk = ~pclk;

    isp_demosaic #(.BITS(B), .WIDTH(W), .HEIGHT(H), .BAYER(0)) dut0 (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
        .out_href(h0), .out_vsync(v0), .out_r(r0), .out_g(g0), .out_b(b0));

    isp_demosaic #(.BITS(B), .WIDTH(W), .HEIGHT(H), .BAYER(3)) dut3 (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
        .out_href(h3), .out_vsync(v3), .out_r(r3), .out_g(g3), .out_b(b3));

    typedef struct {
        logic [23:0] rgb;
        int          row;
        int          col;
    } exp_t;

    exp_t        q0[$];
    exp_t        q3[$];
    int          fr[H][W];
    int          errors = 0;
    int          checks = 0;
    logic        hh[5];
    logic        hv[5];
    logic        hc[5];
    logic [23:0] const_rgb = 24'd0;
    int          nc0 = 0;
    int          nc3 = 0;

    // ---------------- reference model ----------------
    function automatic byte colour_at(input int bayer, input int r, input int c);
        string pat;
        case (bayer)
            0:       pat = "RGGB";
            1:       pat = "GRBG";
            2:       pat = "GBRG";
            default: pat = "BGGR";
        endcase
        return pat[(r % 2) * 2 + (c % 2)];
    endfunction

    function automatic int px(input int r, input int c);
        if (r < 0)  r = 1;
        if (c < 0)  c = 1;
        if (c >= W) c = W - 2;
        return fr[r][c];
    endfunction

    function automatic logic [23:0] model(input int bayer, input int y, input int x);
        int  cy, n, s, e, w, c, d, rr, gg, bb;
        byte k;
        if (y == 0) return 24'd0;
        cy = y - 1;
        c = px(cy, x);
        n = px(cy - 1, x);
        s = px(cy + 1, x);
        w = px(cy, x - 1);
        e = px(cy, x + 1);
        d = px(cy - 1, x - 1) + px(cy - 1, x + 1) + px(cy + 1, x - 1) + px(cy + 1, x + 1);
        k = colour_at(bayer, cy, x);
        if (k == "R") begin
            rr = c; gg = (n + s + e + w) / 4; bb = d / 4;
        end else if (k == "B") begin
            bb = c; gg = (n + s + e + w) / 4; rr = d / 4;
        end else if (colour_at(bayer, cy, x + 1) == "R") begin
            gg = c; rr = (e + w) / 2; bb = (n + s) / 2;
        end else begin
            gg = c; rr = (n + s) / 2; bb = (e + w) / 2;
        end
        return {rr[7:0], gg[7:0], bb[7:0]};
    endfunction

    // ---------------- frame content ----------------
    task automatic fill_flat(input int v);
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) fr[y][x] = v;
    endtask

    task automatic fill_mosaic(input int bayer);
        byte k;
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin
            k = colour_at(bayer, y, x);
            fr[y][x] = (k == "R") ? 200 : (k == "G") ? 100 : 50;
        end
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) fr[y][x] = 4 * x;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) fr[y][x] = int'($urandom_range(0, 255));
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic h, input logic v, input int raw, input logic chk);
        @(posedge pclk);
        #1;
        in_href  = h;
        in_vsync = v;
        in_raw   = raw[7:0];
        in_chk   = chk;
    endtask

    task automatic run_frame(input logic chk, input int rst_row);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        for (int y = 0; y < H; y++) begin
            if (chk) begin
                for (int x = 0; x < W; x++) begin
                    q0.push_back('{model(0, y, x), y, x});
                    q3.push_back('{model(3, y, x), y, x});
                end
            end
            for (int x = 0; x < W; x++) begin
                drive(1, 0, fr[y][x], chk);
                if (y == rst_row && x == 2) begin
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({h0, v0, r0, g0, b0} != 27'd0) begin
                        errors++;
                        $display("FAIL async_reset: outputs=%h required 0", {h0, v0, r0, g0, b0});
                    end
                end
                if (y == rst_row && x == 5) rst_n = 1'b1;
            end
            repeat (2) drive(0, 0, 0, 0);
        end
        repeat (6) drive(0, 0, 0, 0);
    endtask

    task automatic expect_count(input string name, input int got, input logic want_zero);
        checks++;
        if (want_zero ? (got != 0) : (got == 0)) begin
            errors++;
            $display("FAIL %s: pixels off (200/100/50 style constant)=%0d required %s", name, got,
                     want_zero ? "0" : ">0");
        end
    endtask

    initial begin
        repeat (4) @(posedge pclk);
        #1 rst_n = 1'b1;

        fill_rand();
        run_frame(0, -1);

        fill_flat(100);
        const_rgb = {8'd100, 8'd100, 8'd100};
        nc0 = 0; nc3 = 0;
        run_frame(1, -1);
        expect_count("flat_rggb", nc0, 1'b1);
        expect_count("flat_bggr", nc3, 1'b1);

        fill_mosaic(0);
        const_rgb = {8'd200, 8'd100, 8'd50};
        nc0 = 0; nc3 = 0;
        run_frame(1, -1);
        expect_count("mosaic_rggb", nc0, 1'b1);

        fill_mosaic(3);
        nc0 = 0; nc3 = 0;
        run_frame(1, -1);
        expect_count("phase_bggr", nc3, 1'b1);
        expect_count("phase_wrong_bayer", nc0, 1'b0);

        fill_ramp();
        run_frame(1, -1);

        for (int i = 0; i < 200; i++)
            drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0);

        fill_rand();
        run_frame(1, -1);

        fill_rand();
        run_frame(0, 3);

        fill_rand();
        run_frame(1, -1);

        repeat (10) drive(0, 0, 0, 0);
        checks++;
        if (q0.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: left rggb=%0d bggr=%0d required 0", q0.size(), q3.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- monitor ----------------
    task automatic mon_dut(input int id, input logic oh, input logic ov,
                           input logic [7:0] orr, input logic [7:0] og, input logic [7:0] ob);
        exp_t e;
        checks++;
        if (oh !== hh[4] || ov !== hv[4]) begin
            errors++;
            $display("FAIL strobe dut%0d: href/vsync=%b%b required %b%b", id, oh, ov, hh[4], hv[4]);
        end
        if (!oh) begin
            checks++;
            if ({orr, og, ob} !== 24'd0) begin
                errors++;
                $display("FAIL idle_rgb dut%0d: rgb=%h required 0", id, {orr, og, ob});
            end
        end else if (hc[4]) begin
            checks++;
            if ((id == 0) ? (q0.size() == 0) : (q3.size() == 0)) begin
                errors++;
                $display("FAIL sb_underflow dut%0d: output with no expected entry", id);
            end else begin
                e = (id == 0) ? q0.pop_front() : q3.pop_front();
                if ({orr, og, ob} !== e.rgb) begin
                    errors++;
                    $display("FAIL pixel dut%0d row=%0d col=%0d: rgb=%h required %h",
                             id, e.row, e.col, {orr, og, ob}, e.rgb);
                end
                if (e.row >= 1 && {orr, og, ob} != const_rgb) begin
                    if (id == 0) nc0++;
                    else nc3++;
                end
            end
        end
    endtask

    always @(negedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                hh[i] = 1'b0;
                hv[i] = 1'b0;
                hc[i] = 1'b0;
            end
            checks++;
            if ({h0, v0, r0, g0, b0, h3, v3, r3, g3, b3} != 54'd0) begin
                errors++;
                $display("FAIL reset_outputs: %h required 0", {h0, v0, r0, g0, b0, h3, v3, r3, g3, b3});
            end
        end else begin
            for (int i = 4; i > 0; i--) begin
                hh[i] = hh[i-1];
                hv[i] = hv[i-1];
                hc[i] = hc[i-1];
            end
            hh[0] = in_href;
            hv[0] = in_vsync;
            hc[0] = in_chk & in_href;
            mon_dut(0, h0, v0, r0, g0, b0);
            mon_dut(3, h3, v3, r3, g3, b3);
        end
    end

endmodule
